cgra_regfile_mp: RTL

Parametrised multi-channel register file for the CGRA tile datapath. It replaces the fixed three-writer register file. N write channels compete through a round-robin arbiter for one physical write port, and each channel gets a per-channel address plus a valid/ack handshake. Multiple read ports return registered data, and a per-register "written" scoreboard tells the tile sequencer which operands are live.

---
 rtl/cgra_regfile_pkg.sv | 16 +
 rtl/cgra_regfile_mp_rr_arbiter.sv | 62 ++++++
 rtl/cgra_regfile_mp.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cgra_regfile_pkg.sv
// Shared constants and types for the CGRA tile register file.
//   RF_WIDTH      default data width
//   RF_NUM_REGS   default register count (power of two)
//   RF_NUM_WCH    default number of write channels
//   RF_NUM_RPORTS default number of read ports
//   rf_addr_t     register index type for the default configuration
package cgra_regfile_pkg;

    localparam int unsigned RF_WIDTH      = 16;
    localparam int unsigned RF_NUM_REGS   = 16;
    localparam int unsigned RF_NUM_WCH    = 3;
    localparam int unsigned RF_NUM_RPORTS = 4;

    typedef logic [$clog2(RF_NUM_REGS)-1:0] rf_addr_t;

endpackage

// File: rtl/cgra_regfile_mp_rr_arbiter.sv
// Round-robin arbiter granting at most one requester per cycle.
//   clk, reset : clock and synchronous active-high reset
//   req        : per-requester request vector
//   en         : when low, no grant is issued and the pointer holds
//   gnt        : one-hot grant (all zero when nothing is granted)
//   gnt_idx    : index of the granted requester (0 when nothing is granted)
// The search starts at rr_ptr; after a grant to g the pointer moves to (g+1) mod N.
module rr_arbiter
    import cgra_regfile_pkg::*;
#(
    parameter int unsigned N  = RF_NUM_WCH,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic          found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        rr_ptr_d = rr_ptr_q;
        if (en) begin
            // First pass: requesters at or above the pointer.
            for (int j = 0; j < int'(N); j++) begin
                if (!found && req[j] && (IW'(j) >= rr_ptr_q)) begin
                    found   = 1'b1;
                    gnt_idx = IW'(j);
                end
            end
            // Second pass wraps around to requesters below the pointer.
            for (int j = 0; j < int'(N); j++) begin
                if (!found && req[j]) begin
                    found   = 1'b1;
                    gnt_idx = IW'(j);
                end
            end
            if (found) begin
                for (int j = 0; j < int'(N); j++) begin
                    gnt[j] = (gnt_idx == IW'(j));
                end
                rr_ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/cgra_regfile_mp.sv
// Multi-channel register file for the CGRA tile datapath.
//   clk, reset  : clock and synchronous active-high reset
//   wen         : per-channel write request; addr/data held until wr_ack
//   w_addr      : per-channel target register, packed channel-major
//   w_data      : per-channel write data, packed channel-major
//   wr_ack      : one-cycle pulse when that channel's write committed
//   ren         : read enable shared by all read ports
//   r_addr      : per-port read address, packed port-major
//   r_data      : per-port registered read data
//   r_valid     : r_data was updated at the last edge
//   clr_written : clears the written scoreboard (a same-edge commit still sets its bit)
//   written     : bit k = register k written since last clear or reset
module cgra_regfile_mp
    import cgra_regfile_pkg::*;
#(
    parameter int unsigned WIDTH          = RF_WIDTH,
    parameter int unsigned NUM_REGS       = RF_NUM_REGS,
    parameter int unsigned NUM_WCH        = RF_NUM_WCH,
    parameter int unsigned NUM_RPORTS     = RF_NUM_RPORTS,
    parameter int unsigned BLOCK_WR_ON_RD = 1,
    parameter int unsigned RD_BYPASS      = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_WCH-1:0]            wen,
    input  logic [NUM_WCH*$clog2(NUM_REGS)-1:0]    w_addr,
    input  logic [NUM_WCH*WIDTH-1:0]      w_data,
    output logic [NUM_WCH-1:0]            wr_ack,
    input  logic                          ren,
    input  logic [NUM_RPORTS*$clog2(NUM_REGS)-1:0] r_addr,
    output logic [NUM_RPORTS*WIDTH-1:0]   r_data,
    output logic                          r_valid,
    input  logic                          clr_written,
    output logic [NUM_REGS-1:0]           written
);

    localparam int unsigned AW = $clog2(NUM_REGS);
    localparam int unsigned IW = (NUM_WCH > 1) ? $clog2(NUM_WCH) : 1;

    logic [WIDTH-1:0]            regs_q [NUM_REGS];
    logic [WIDTH-1:0]            regs_d [NUM_REGS];
    logic [NUM_RPORTS*WIDTH-1:0] r_data_q, r_data_d;
    logic                        r_valid_q, r_valid_d;
    logic [NUM_WCH-1:0]          wr_ack_q, wr_ack_d;
    logic [NUM_REGS-1:0]         written_q, written_d;

    logic [NUM_WCH-1:0] req;
    logic [NUM_WCH-1:0] gnt;
    logic [IW-1:0]      gnt_idx;
    logic               arb_en;
    logic               commit;
    logic [AW-1:0]      cm_addr;
    logic [WIDTH-1:0]   cm_data;

    // A channel in its ack cycle still shows the old request; masking it
    // stops the same write from committing twice.
    assign req    = wen & ~wr_ack_q;
    assign arb_en = (BLOCK_WR_ON_RD != 0) ? ~ren : 1'b1;
    assign commit = |gnt;

    rr_arbiter #(
        .N  (NUM_WCH),
        .IW (IW)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        cm_addr = '0;
        cm_data = '0;
        for (int c = 0; c < int'(NUM_WCH); c++) begin
            if (gnt_idx == IW'(c)) begin
                cm_addr = w_addr[c*AW +: AW];
                cm_data = w_data[c*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (commit) begin
            regs_d[cm_addr] = cm_data;
        end
    end

    // Set wins over clear when a commit lands on the clearing edge.
    always_comb begin
        written_d = clr_written ? '0 : written_q;
        if (commit) begin
            written_d[cm_addr] = 1'b1;
        end
    end

    assign wr_ack_d  = gnt;
    assign r_valid_d = ren;

    always_comb begin
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] rd;
        ra       = '0;
        rd       = '0;
        r_data_d = r_data_q;
        if (ren) begin
            for (int i = 0; i < int'(NUM_RPORTS); i++) begin
                ra = r_addr[i*AW +: AW];
                rd = regs_q[ra];
                if ((RD_BYPASS != 0) && commit && (ra == cm_addr)) begin
                    rd = cm_data;
                end
                r_data_d[i*WIDTH +: WIDTH] = rd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < int'(NUM_REGS); k++) begin
                regs_q[k] <= '0;
            end
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
            wr_ack_q  <= '0;
            written_q <= '0;
        end else begin
            regs_q    <= regs_d;
            r_data_q  <= r_data_d;
            r_valid_q <= r_valid_d;
            wr_ack_q  <= wr_ack_d;
            written_q <= written_d;
        end
    end

    assign wr_ack  = wr_ack_q;
    assign r_data  = r_data_q;
    assign r_valid = r_valid_q;
    assign written = written_q;

endmodule
